// File: rtl/fp_math_arbiter.sv
// Round-robin arbiter sharing one Q12.20 multiplier and divider among N_REQ requesters.
// Accept-to-result is MUL_LAT/DIV_LAT cycles, and each operation occupies LAT+2 cycles. Nothing is accepted while BUSY/RESP.
module fp_math_arbiter #(
    parameter int N_REQ   = 4,
    parameter int MUL_LAT = 1,
    parameter int DIV_LAT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ-1:0]      req_op,
    input  logic [32*N_REQ-1:0]   req_a,
    input  logic [32*N_REQ-1:0]   req_b,
    output logic [N_REQ-1:0]      req_ready,
    output logic [N_REQ-1:0]      rsp_valid,
    output logic [31:0]           rsp_data,
    output logic                  rsp_err,
    output logic                  busy
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [31:0]      op_a_q, op_a_d, op_b_q, op_b_d;
    logic             op_div_q, op_div_d;
    logic [PW-1:0]    gnt_q, gnt_d;
    logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [31:0]      rsp_data_q, rsp_data_d;
    logic             rsp_err_q, rsp_err_d;

    logic             gnt_any;
    logic [PW-1:0]    gnt_idx;
    logic [31:0]      sel_a, sel_b;
    logic             sel_op;

    // Two passes: first requesters at or above the pointer, then wrap to the bottom.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!gnt_any && req_valid[i] && (PW'(i) >= ptr_q)) begin
                gnt_any = 1'b1;
                gnt_idx = PW'(i);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!gnt_any && req_valid[i]) begin
                gnt_any = 1'b1;
                gnt_idx = PW'(i);
            end
        end
    end

    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (PW'(i) == gnt_idx) begin
                sel_a  = req_a[32*i +: 32];
                sel_b  = req_b[32*i +: 32];
                sel_op = req_op[i];
            end
        end
    end

    // Shared arithmetic, fed only from the latched operand registers.
    logic signed [63:0] prod, num, quot;
    logic [31:0]        mul_res, div_res, dz_res;
    logic               div_zero;
    logic               unused_bits;

    assign div_zero    = (op_b_q == 32'd0);
    assign prod        = 64'($signed(op_a_q)) * 64'($signed(op_b_q));
    assign num         = 64'($signed(op_a_q)) <<< 20;
    assign quot        = div_zero ? 64'sd0 : (num / 64'($signed(op_b_q)));
    assign mul_res     = prod[51:20];
    assign div_res     = quot[31:0];
    assign dz_res      = op_a_q[31] ? 32'h8000_0001 : 32'h7FFF_FFFF;
    assign unused_bits = ^{prod[63:52], prod[19:0], quot[63:32]};

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_div_d    = op_div_q;
        gnt_d       = gnt_q;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_any) begin
                    op_a_d   = sel_a;
                    op_b_d   = sel_b;
                    op_div_d = sel_op;
                    gnt_d    = gnt_idx;
                    cnt_d    = sel_op ? 4'(DIV_LAT - 1) : 4'(MUL_LAT - 1);
                    ptr_d    = (gnt_idx == PW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                    state_d  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt_q == 4'd0) begin
                    rsp_data_d         = !op_div_q ? mul_res : (div_zero ? dz_res : div_res);
                    rsp_err_d          = op_div_q && div_zero;
                    rsp_valid_d[gnt_q] = 1'b1;
                    state_d            = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_div_q    <= 1'b0;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_div_q    <= op_div_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE && gnt_any && !reset) ? (N_REQ'(1) << gnt_idx) : '0;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = (state_q != ST_IDLE);
endmodule

// File: tb/tb_fp_math_arbiter.sv
// Directed bench for fp_math_arbiter: latency, arithmetic, divide-by-zero, reset abort, fairness.
module tb_fp_math_arbiter;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_op = '0;
    logic [32*N-1:0] req_a = '0;
    logic [32*N-1:0] req_b = '0;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   rsp_valid;
    logic [31:0]    rsp_data;
    logic           rsp_err;
    logic           busy;

    int errors = 0;
    int checks = 0;

    fp_math_arbiter #(.N_REQ(N), .MUL_LAT(1), .DIV_LAT(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic op, input logic [31:0] a, input logic [31:0] b);
        req_valid[i]      = 1'b1;
        req_op[i]         = op;
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
    endtask

    // Single isolated request; operands are disturbed right after acceptance.
    task automatic run_op(input string tag, input int i, input logic op, input logic [31:0] a,
                          input logic [31:0] b, input int lat, input logic [31:0] exp_d,
                          input logic exp_e);
        set_req(i, op, a, b);
        #1;
        check({tag, "/ready"}, 32'(req_ready), 32'(1 << i));
        tick;
        req_valid[i]      = 1'b0;
        req_a[32*i +: 32] = ~a;
        req_b[32*i +: 32] = b + 32'h0010_0000;
        for (int k = 0; k < lat; k++) begin
            check({tag, "/busy"}, 32'(busy), 32'd1);
            check({tag, "/early_rsp"}, 32'(rsp_valid), 32'd0);
            tick;
        end
        check({tag, "/rsp_valid"}, 32'(rsp_valid), 32'(1 << i));
        check({tag, "/rsp_data"}, rsp_data, exp_d);
        check({tag, "/rsp_err"}, 32'(rsp_err), 32'(exp_e));
        check({tag, "/busy_resp"}, 32'(busy), 32'd1);
        tick;
        check({tag, "/rsp_clear"}, 32'(rsp_valid), 32'd0);
        check({tag, "/idle"}, 32'(busy), 32'd0);
        check({tag, "/hold"}, rsp_data, exp_d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] fair_res [4];
        int          t;

        // Reset state, including ready gating while requests are present.
        repeat (3) @(posedge clk);
        #1;
        req_valid = 4'b1111;
        #1;
        check("rst/ready", 32'(req_ready), 32'd0);
        check("rst/busy", 32'(busy), 32'd0);
        check("rst/rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst/rsp_data", rsp_data, 32'd0);
        check("rst/rsp_err", 32'(rsp_err), 32'd0);
        req_valid = '0;
        reset = 1'b0;
        tick;

        run_op("mul1", 1, 1'b0, 32'h0020_0000, 32'h0050_0000, 1, 32'h00A0_0000, 1'b0);
        run_op("div0", 0, 1'b1, 32'h00A0_0000, 32'h0020_0000, 4, 32'h0050_0000, 1'b0);
        run_op("dz_pos", 3, 1'b1, 32'h0010_0000, 32'h0000_0000, 4, 32'h7FFF_FFFF, 1'b1);
        run_op("dz_neg", 2, 1'b1, 32'hFFD0_0000, 32'h0000_0000, 4, 32'h8000_0001, 1'b1);
        run_op("mul_neg", 1, 1'b0, 32'hFFD0_0000, 32'h0020_0000, 1, 32'hFFA0_0000, 1'b0);
        run_op("div_neg", 3, 1'b1, 32'hFFD0_0000, 32'h0020_0000, 4, 32'hFFE8_0000, 1'b0);
        run_op("mul_frac", 2, 1'b0, 32'h0018_0000, 32'h0008_0000, 1, 32'h000C_0000, 1'b0);

        // Reset in the middle of a divide.
        set_req(2, 1'b1, 32'h00A0_0000, 32'h0020_0000);
        #1;
        check("abort/ready", 32'(req_ready), 32'b0100);
        tick;
        req_valid = '0;
        tick;
        #2;
        reset = 1'b1;
        #1;
        check("abort/busy", 32'(busy), 32'd0);
        check("abort/rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort/rsp_data", rsp_data, 32'd0);
        set_req(1, 1'b0, 32'h0020_0000, 32'h0050_0000);
        set_req(3, 1'b1, 32'h00A0_0000, 32'h0020_0000);
        #1;
        check("abort/ready_gated", 32'(req_ready), 32'd0);
        tick;
        tick;
        check("abort/no_rsp", 32'(rsp_valid), 32'd0);
        reset = 1'b0;
        #1;
        check("abort/first_grant", 32'(req_ready), 32'b0010);
        tick;
        tick;
        check("abort/rsp_valid2", 32'(rsp_valid), 32'b0010);
        check("abort/rsp_data2", rsp_data, 32'h00A0_0000);
        req_valid = '0;
        tick;

        // Fairness: all four valid from reset and held throughout.
        reset = 1'b1;
        set_req(0, 1'b0, 32'h0020_0000, 32'h0050_0000);
        set_req(1, 1'b1, 32'h00A0_0000, 32'h0020_0000);
        set_req(2, 1'b0, 32'h0018_0000, 32'h0008_0000);
        set_req(3, 1'b1, 32'hFFD0_0000, 32'h0020_0000);
        fair_res[0] = 32'h00A0_0000;
        fair_res[1] = 32'h0050_0000;
        fair_res[2] = 32'h000C_0000;
        fair_res[3] = 32'hFFE8_0000;
        tick;
        tick;
        reset = 1'b0;
        #1;
        for (int n = 0; n < 5; n++) begin
            t = 0;
            while (req_ready == '0 && t < 20) begin
                tick;
                t++;
            end
            check($sformatf("fair%0d/ready", n), 32'(req_ready), 32'(1 << (n % 4)));
            tick;
            t = 0;
            while (rsp_valid == '0 && t < 20) begin
                check($sformatf("fair%0d/ready_busy", n), 32'(req_ready), 32'd0);
                tick;
                t++;
            end
            check($sformatf("fair%0d/rsp_valid", n), 32'(rsp_valid), 32'(1 << (n % 4)));
            check($sformatf("fair%0d/rsp_data", n), rsp_data, fair_res[n % 4]);
            check($sformatf("fair%0d/rsp_err", n), 32'(rsp_err), 32'd0);
            tick;
        end
        req_valid = '0;
        tick;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
